serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor; the sequential successor to the combinational half-adder cell.
- Uses one full-adder cell and a carry flip-flop to process one bit per clock, LSB first.
- Takes WIDTH-bit operands through a start/done handshake and returns the sum, carry-out and signed overflow.
- Used as the arithmetic engine in the lab datapath where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result; holds until the next accepted start.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

Interface (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, any time including mid-RUN):
  - state=IDLE; busy, done, sum, cout, ovf, carry, counter and shift registers all 0.
  - An aborted operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at edge E0: a_sh<=a; b_sh<=sub ? ~b : b; carry<=sub; cnt<=0; go to RUN. busy=1 from E0.
  - start=0: stay in IDLE; outputs hold.
- RUN, one bit per edge E1..E_WIDTH:
  - s = a_sh[0]^b_sh[0]^carry; c = majority(a_sh[0], b_sh[0], carry).
  - res_sh shifts right with s entering at the MSB; a_sh and b_sh shift right.
  - carry<=c; cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1, the carry into the MSB is captured as cmsb.
  - After edge E_WIDTH: state=DONE; sum<=final res_sh; cout<=final carry; ovf<=cmsb^cout; busy=0.
- DONE:
  - done=1 for exactly one cycle; next edge returns to IDLE.
  - start asserted in DONE is ignored; it is accepted only in IDLE.
- Latency:
  - start sampled at E0; done high during the cycle after E_WIDTH.
  - Earliest next start is sampled at E_{WIDTH+2}.
  - Throughput: one operation per WIDTH+2 cycles.
- start, sub, a and b are ignored while busy or done. Operands may change freely after E0.
- Arithmetic is modulo 2^WIDTH; no saturation. Subtraction is a + ~b + 1.
- WIDTH=1: RUN lasts one cycle; cmsb is the initial carry (sub).

Decomposition:
- Package serial_addsub_pkg:
  - state typedef/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - WIDTH bounds check constant.
- Sub-module fa: 1-bit combinational full adder (a, b, cin -> s, cout), built from two half-adder cells plus OR.
- The top level holds the FSM, shift registers, counter and carry flop.

Test Plan (WIDTH=8 unless stated):
- 100+55 (sub=0) -> done pulse at cycle 9 after start edge; sum=0x9B, cout=0, ovf=1; busy high exactly 8 cycles.
- 200+100 -> sum=0x2C, cout=1, ovf=0; then 0xFF+0x01 -> sum=0x00, cout=1, ovf=0.
- sub: 5-7 -> sum=0xFE, cout=0, ovf=0; 0x80-1 -> sum=0x7F, cout=1, ovf=1; 7-7 -> sum=0x00, cout=1, ovf=0.
- start held high continuously with changing a/b -> operands captured only at IDLE edges; results match the captured values; DONE-cycle start ignored; done never overlaps busy.
- rst_n pulsed low mid-RUN (cycle 4) -> all outputs 0 immediately (asynchronous), no done; a fresh start after release gives the correct result.
- WIDTH=1 and WIDTH=32 instances: exhaustive 1-bit add/sub with sum, cout, ovf matching a reference model; random 32-bit vectors with done at cycle 33.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_pkg
// Description : Shared types and constants for the bit-serial adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_addsub_pkg;

   // Controller states; width fixed at two bits
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Supported operand width range
   localparam int c_WIDTH_MIN = 1;
   localparam int c_WIDTH_MAX = 64;

   // True when an operand width lies inside the supported range
   function automatic logic width_ok(input int w);
      return (w >= c_WIDTH_MIN) && (w <= c_WIDTH_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_addsub_fa.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_fa
// Description : 1-bit combinational full adder made of two half-adder stages
//               and an OR for the carry.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   import serial_addsub_pkg::*;

   logic w_hs1_s;
   logic w_hs1_c;
   logic w_hs2_c;

   // First half adder: operand bits
   assign w_hs1_s = a ^ b;
   assign w_hs1_c = a & b;

   // Second half adder: partial sum plus incoming carry
   assign s       = w_hs1_s ^ cin;
   assign w_hs2_c = w_hs1_s & cin;

   // Either stage may generate the carry, never both at once
   assign cout    = w_hs1_c | w_hs2_c;

endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial adder/subtractor. One full-adder cell plus a carry
//               flop process one bit per clock, LSB first, behind a
//               start/done handshake. Subtraction is a + ~b + 1.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   import serial_addsub_pkg::*;

   // Index of the last bit processed in RUN
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

   if (!width_ok(WIDTH)) begin : g_width_check
      $error("serial_addsub: WIDTH out of supported range 1..64");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res_sh;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_busy;
   logic             r_done;

   logic             w_s;
   logic             w_c;
   logic [WIDTH-1:0] w_res_next;

   // The single arithmetic cell works on the current LSBs and carry
   serial_addsub_fa u_fa (
      .a    (r_a_sh[0]),
      .b    (r_b_sh[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   // Result register shifts right with the new bit entering at the MSB
   if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_s;
   end else begin : g_res_wn
      assign w_res_next = {w_s, r_res_sh[WIDTH-1:1]};
   end

   // Controller, datapath shift registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res_sh <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  // Subtraction: invert b and seed the carry with 1
                  r_a_sh  <= a;
                  r_b_sh  <= sub ? ~b : b;
                  r_carry <= sub;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_res_sh <= w_res_next;
               r_carry  <= w_c;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (r_cnt == c_LAST) begin
                  // r_carry is the carry into the MSB at this edge, so the
                  // overflow is formed directly without a separate flop
                  r_sum   <= w_res_next;
                  r_cout  <= w_c;
                  r_ovf   <= r_carry ^ w_c;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub at WIDTH 1, 8 and 32
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        start1, sub1, busy1, done1, cout1, ovf1;
   logic [0:0]  a1, b1, sum1;
   logic        start8, sub8, busy8, done8, cout8, ovf8;
   logic [7:0]  a8, b8, sum8;
   logic        start32, sub32, busy32, done32, cout32, ovf32;
   logic [31:0] a32, b32, sum32;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

   serial_addsub #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

   serial_addsub #(.WIDTH(32)) u_w32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32));

   // One comparison point
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain modular arithmetic and sign rules
   function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, output logic [63:0] s,
                                 output logic co, output logic ov);
      logic [64:0] mask;
      logic [64:0] full;
      logic [63:0] am, bm;
      logic        sa, sb, ss;
      mask = (65'd1 << w) - 65'd1;
      am   = a & mask[63:0];
      bm   = sub ? (~b & mask[63:0]) : (b & mask[63:0]);
      full = {1'b0, am} + {1'b0, bm} + {64'd0, sub};
      s    = full[63:0] & mask[63:0];
      co   = full[w];
      sa   = a[w-1];
      sb   = b[w-1];
      ss   = s[w-1];
      ov   = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
   endfunction

   task automatic drive(input int w, input logic st, input logic sb,
                        input logic [63:0] a, input logic [63:0] b);
      case (w)
         1:       begin start1  = st; sub1  = sb; a1  = a[0:0];  b1  = b[0:0];  end
         8:       begin start8  = st; sub8  = sb; a8  = a[7:0];  b8  = b[7:0];  end
         default: begin start32 = st; sub32 = sb; a32 = a[31:0]; b32 = b[31:0]; end
      endcase
   endtask

   function automatic void get(input int w, output logic bz, output logic dn,
                               output logic [63:0] s, output logic co, output logic ov);
      case (w)
         1:       begin bz = busy1;  dn = done1;  s = 64'(sum1);  co = cout1;  ov = ovf1;  end
         8:       begin bz = busy8;  dn = done8;  s = 64'(sum8);  co = cout8;  ov = ovf8;  end
         default: begin bz = busy32; dn = done32; s = 64'(sum32); co = cout32; ov = ovf32; end
      endcase
   endfunction

   // One full operation with latency, busy-length and result checks
   task automatic do_op(input int w, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input string tag);
      logic [63:0] s, es;
      logic        bz, dn, co, ov, eco, eov;
      int          busy_n, done_n, done_at, overlap;
      model(w, a, b, sub, es, eco, eov);
      busy_n = 0; done_n = 0; done_at = -1; overlap = 0;
      @(negedge clk);
      drive(w, 1'b1, sub, a, b);
      @(posedge clk); #1;
      drive(w, 1'b0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      get(w, bz, dn, s, co, ov);
      if (bz) busy_n++;
      for (int k = 1; k <= w + 1; k++) begin
         @(posedge clk); #1;
         get(w, bz, dn, s, co, ov);
         if (bz) busy_n++;
         if (bz && dn) overlap++;
         if (dn) begin
            done_n++;
            done_at = k;
            check({tag, "_sum"},  s,       es);
            check({tag, "_cout"}, 64'(co), 64'(eco));
            check({tag, "_ovf"},  64'(ov), 64'(eov));
         end
      end
      check({tag, "_done_at"},   64'(done_at), 64'(w));
      check({tag, "_done_n"},    64'(done_n),  64'd1);
      check({tag, "_busy_n"},    64'(busy_n),  64'(w));
      check({tag, "_overlap"},   64'(overlap), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] s, es;
      logic        bz, dn, co, ov, eco, eov;
      logic [7:0]  qa [30];
      logic [7:0]  qb [30];
      logic        qs [30];
      int          dn_cnt;

      rst_n = 1'b0;
      drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
      drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
      drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
      #12;
      get(8, bz, dn, s, co, ov);
      check("rst_busy", 64'(bz), 64'd0);
      check("rst_done", 64'(dn), 64'd0);
      check("rst_sum",  s,       64'd0);
      check("rst_cout", 64'(co), 64'd0);
      check("rst_ovf",  64'(ov), 64'd0);
      get(32, bz, dn, s, co, ov);
      check("rst32_flags", {61'd0, bz, dn, co}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed WIDTH=8 vectors
      do_op(8, 64'd100,  64'd55,   1'b0, "add_100_55");
      do_op(8, 64'd200,  64'd100,  1'b0, "add_200_100");
      do_op(8, 64'hFF,   64'h01,   1'b0, "add_ff_01");
      do_op(8, 64'd5,    64'd7,    1'b1, "sub_5_7");
      do_op(8, 64'h80,   64'h01,   1'b1, "sub_80_1");
      do_op(8, 64'd7,    64'd7,    1'b1, "sub_7_7");

      // Spot-check the model against hand-computed results
      model(8, 64'd100, 64'd55, 1'b0, es, eco, eov);
      check("ref_100_55", {es[61:0], eco, eov}, {62'h9B, 1'b0, 1'b1});

      // Random WIDTH=8
      for (int i = 0; i < 6; i++)
         do_op(8, 64'($urandom), 64'($urandom), 1'($urandom), "rand8");

      // start held high: captures only at IDLE edges, every WIDTH+2 cycles
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         qa[c] = 8'($urandom);
         qb[c] = 8'($urandom);
         qs[c] = 1'($urandom);
         drive(8, 1'b1, qs[c], 64'(qa[c]), 64'(qb[c]));
         @(posedge clk); #1;
         get(8, bz, dn, s, co, ov);
         check("hold_done", 64'(dn), 64'((c % 10) == 8));
         check("hold_busy", 64'(bz), 64'((c % 10) < 8));
         if (((c % 10) == 8) && dn) begin
            model(8, 64'(qa[c-8]), 64'(qb[c-8]), qs[c-8], es, eco, eov);
            check("hold_sum",  s,       es);
            check("hold_cout", 64'(co), 64'(eco));
            check("hold_ovf",  64'(ov), 64'(eov));
         end
      end
      @(negedge clk);
      drive(8, 1'b0, 1'b0, 64'd0, 64'd0);

      // Make sure sum is nonzero before the abort
      do_op(8, 64'h12, 64'h34, 1'b0, "pre_abort");

      // Asynchronous reset in the middle of RUN
      @(negedge clk);
      drive(8, 1'b1, 1'b0, 64'hA5, 64'h3C);
      @(posedge clk); #1;
      drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      get(8, bz, dn, s, co, ov);
      check("abort_busy", 64'(bz), 64'd0);
      check("abort_done", 64'(dn), 64'd0);
      check("abort_sum",  s,       64'd0);
      check("abort_cout", 64'(co), 64'd0);
      check("abort_ovf",  64'(ov), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      dn_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         get(8, bz, dn, s, co, ov);
         if (dn || bz) dn_cnt++;
      end
      check("abort_no_done", 64'(dn_cnt), 64'd0);
      do_op(8, 64'hA5, 64'h3C, 1'b0, "after_abort");

      // Exhaustive WIDTH=1
      for (int i = 0; i < 8; i++)
         do_op(1, 64'(i & 1), 64'((i >> 1) & 1), 1'((i >> 2) & 1), "w1");

      // Random WIDTH=32
      for (int i = 0; i < 8; i++)
         do_op(32, 64'($urandom), 64'($urandom), 1'($urandom), "rand32");
      do_op(32, 64'h7FFFFFFF, 64'd1,         1'b0, "w32_pos_ovf");
      do_op(32, 64'h80000000, 64'd1,         1'b1, "w32_neg_ovf");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
